pedge_event_serializer: RTL and testbench
=========================================

// Module: pedge_event_serializer
// PURPOSE
// - Consumes the per-bit one-cycle rising-edge pulses from the edge-sync stage (8-bit pedge vector).
// - Latches each pulse as a pending event; serializes pending events into a valid/ready stream of channel indices.
// - Fair round-robin service across channels; sticky per-channel overflow flags when a pulse merges into a pending event.
// PARAMETERS
// - WIDTH   8   number of pulse channels (>=2)
// - TS_W    16  timestamp width (used only with PEDGE_TIMESTAMP_EN)
// PORTS
// - clk       in   1           system clock
// - rst       in   1           synchronous reset, active-high
// - pedge     in   WIDTH       one-cycle edge pulses, bit i = channel i
// - ev_valid  out  1           event available
// - ev_ready  in   1           downstream accepts event when ev_valid && ev_ready
// - ev_chan   out  CHAN_W      channel index of event, CHAN_W = $clog2(WIDTH)
// - ev_ts     out  TS_W        capture timestamp (present only with PEDGE_TIMESTAMP_EN)
// - pending   out  WIDTH       registered pending bitmap (status)
// - overflow  out  WIDTH       sticky per-channel overflow flags
// - ovf_clr   in   WIDTH       per-bit clear of overflow
// BEHAVIOUR
// - Reset (rst=1 at posedge): ev_valid=0, ev_chan=0, ev_ts=0, pending=0, overflow=0, rr pointer=0, ts counter=0. Mid-operation reset drops all events incl. one held in output reg.
// - Request vector req = pending | pedge (same-cycle pulse eligible for grant).
// - Output reg loads when load = !ev_valid || ev_ready; if load && |req: grant g = first set bit of req at/after ptr (wrap WIDTH-1 -> 0); ev_valid<=1, ev_chan<=g; ptr<=(g+1) mod WIDTH. If load && !|req: ev_valid<=0.
// - Latency: pedge[i] in cycle n, output idle, no other req -> ev_valid=1, ev_chan=i in cycle n+1.
// - Throughput: 1 event/cycle with ev_ready held high.
// - Backpressure: ev_valid && !ev_ready holds ev_chan/ev_ts stable; no grant that cycle.
// - pending[i] next: set if pedge[i] and not (granted i this cycle with pending[i]=0); cleared if granted i and !pedge[i]; stays 1 if granted i, pending[i]=1 and pedge[i]=1 (new event retained).
// - Overflow: pedge[i] && pending[i] && !(grant of i this cycle) -> events merge, overflow[i]<=1. ovf_clr[i] clears; set and clear same cycle -> set wins.
// - Granted channel is consumed when loaded into output reg, not when accepted downstream.
// - ev_chan width: CHAN_W; WIDTH not power of 2 -> indices >= WIDTH never issued.
// CONFIGURATION
// - PEDGE_TIMESTAMP_EN defined: free-running TS_W counter (wraps 2^TS_W-1 -> 0); per-channel ts_q[i] captured = counter when pending[i] is set (merged pulse keeps first ts); same-cycle pass-through uses current counter; ev_ts loaded with ev_chan.
// - PEDGE_TIMESTAMP_EN undefined: no counter, no ts regs, no ev_ts port; all other behaviour identical.
// STRUCTURE
// - Package pedge_ser_pkg: localparam-style function chan_w(WIDTH), typedef struct {chan, ts} ev_t, default widths.
// - Sub-module rr_arbiter #(WIDTH): inputs req, ptr; outputs gnt_vld, gnt_idx (combinational, rotate-priority).
// - Top: pending/overflow regs, ptr reg, output reg, optional ts counter/regs.
// TESTING
// - rst 3 cycles then pedge=8'h02 one cycle, ev_ready=1 -> next cycle ev_valid=1, ev_chan=1; following cycle ev_valid=0; overflow=0.
// - pedge=8'h0E one cycle, ev_ready=1 -> ev_chan 1,2,3 on 3 consecutive cycles; then ev_valid=0, pending=0.
// - ev_ready=0, pedge=8'h02 twice (cycles 3 apart) -> ev_chan=1 held stable, overflow=8'h02 only if second pulse hits while pending[1]=1 (issue after first load: pending=8'h02, no overflow); third pulse -> overflow=8'h02; ovf_clr=8'h02 -> 0.
// - Fairness: pedge=8'h81 every cycle, ev_ready=1 -> ev_chan alternates 0,7,0,7; no channel starved.
// - rst asserted while ev_valid=1 and pending=8'h30 -> next cycle ev_valid=0, pending=0, ptr restarts at 0 (pedge=8'h81 then grants 0 first).
// - With PEDGE_TIMESTAMP_EN, TS_W=4: pulse on ch2 at counter=15, ev_ready=0 for 3 cycles -> ev_ts=15 held; counter wraps to 0 without affecting ev_ts.

Source files
------------

// File: rtl/pedge_ser_pkg.sv
// Shared widths, helpers and event type for the pedge event serializer.
package pedge_ser_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TS_W  = 16;

  function automatic int chan_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int DEF_CHAN_W = chan_w(DEF_WIDTH);

  typedef struct packed {
    logic [DEF_CHAN_W-1:0] chan;
    logic [DEF_TS_W-1:0]   ts;
  } ev_t;

endpackage

// File: rtl/pedge_event_serializer_if.sv
// Event stream (valid/ready + channel index, optional timestamp).
// ev_ts exists only when PEDGE_TIMESTAMP_EN is defined.
interface pedge_event_serializer_if
  import pedge_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TS_W  = DEF_TS_W
);
  localparam int CHAN_W = chan_w(WIDTH);

  logic              ev_valid;
  logic              ev_ready;
  logic [CHAN_W-1:0] ev_chan;

  if (WIDTH < 2 || TS_W < 1) begin : g_bad_cfg
    $error("pedge_event_serializer_if: WIDTH must be >= 2 and TS_W >= 1");
  end

`ifdef PEDGE_TIMESTAMP_EN
  logic [TS_W-1:0]   ev_ts;
  modport master (output ev_valid, ev_chan, ev_ts, input ev_ready);
  modport slave  (input ev_valid, ev_chan, ev_ts, output ev_ready);
`else
  modport master (output ev_valid, ev_chan, input ev_ready);
  modport slave  (input ev_valid, ev_chan, output ev_ready);
`endif

endinterface

// File: rtl/pedge_event_serializer_rr_arbiter.sv
// Rotate-priority arbiter: grants the first set req bit at or after ptr,
// wrapping WIDTH-1 -> 0. Purely combinational.
module rr_arbiter
  import pedge_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CW   = chan_w(WIDTH)
)(
  input  logic [WIDTH-1:0] req,
  input  logic [CW-1:0]    ptr,
  output logic             gnt_vld,
  output logic [CW-1:0]    gnt_idx
);

  logic [CW:0] j;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (CW+1)'(k);
      if (j >= (CW+1)'(WIDTH)) j = j - (CW+1)'(WIDTH);
      if (req[j[CW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = j[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/pedge_event_serializer.sv
// Latches one-cycle edge pulses as pending events and serializes them
// round-robin onto a valid/ready channel-index stream. Option: PEDGE_TIMESTAMP_EN.
module pedge_event_serializer
  import pedge_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TS_W  = DEF_TS_W
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pedge,
  pedge_event_serializer_if.master ev,
  output logic [WIDTH-1:0]         pending,
  output logic [WIDTH-1:0]         overflow,
  input  logic [WIDTH-1:0]         ovf_clr
);

  localparam int CHAN_W = chan_w(WIDTH);

  if (WIDTH < 2 || TS_W < 1) begin : g_bad_cfg
    $error("pedge_event_serializer: WIDTH must be >= 2 and TS_W >= 1");
  end

  logic [WIDTH-1:0]  req, gmask, set_ovf;
  logic              load, take, gnt_vld;
  logic [CHAN_W-1:0] gnt_idx, ptr, ptr_nxt;
  logic              ev_valid_q;
  logic [CHAN_W-1:0] ev_chan_q;

  rr_arbiter #(.WIDTH(WIDTH)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Same-cycle pulses compete alongside already-pending events.
  assign req     = pending | pedge;
  assign load    = !ev_valid_q || ev.ev_ready;
  assign take    = load && gnt_vld;
  assign gmask   = take ? (WIDTH'(1) << gnt_idx) : '0;
  assign set_ovf = pedge & pending & ~gmask;
  assign ptr_nxt = (gnt_idx == CHAN_W'(WIDTH - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      overflow   <= '0;
      ptr        <= '0;
      ev_valid_q <= 1'b0;
      ev_chan_q  <= '0;
    end else begin
      // A granted pass-through pulse is consumed; a pulse landing on a granted
      // pending event is kept as a fresh event.
      pending  <= (pending & ~gmask) | (pedge & ~(gmask & ~pending));
      overflow <= (overflow & ~ovf_clr) | set_ovf;
      if (load) begin
        ev_valid_q <= gnt_vld;
        if (gnt_vld) begin
          ev_chan_q <= gnt_idx;
          ptr       <= ptr_nxt;
        end
      end
    end
  end

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_chan  = ev_chan_q;

`ifdef PEDGE_TIMESTAMP_EN
  logic [TS_W-1:0]            ts_cnt, ev_ts_q;
  logic [WIDTH-1:0][TS_W-1:0] ts_q;
  logic [WIDTH-1:0]           cap;

  // Capture on a fresh pending event; a merged pulse keeps the first stamp.
  assign cap = pedge & (~pending | gmask);

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt  <= '0;
      ev_ts_q <= '0;
      ts_q    <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (take) ev_ts_q <= pending[gnt_idx] ? ts_q[gnt_idx] : ts_cnt;
      for (int i = 0; i < WIDTH; i++)
        if (cap[i]) ts_q[i] <= ts_cnt;
    end
  end

  assign ev.ev_ts = ev_ts_q;
`endif

endmodule

// File: tb/tb_pedge_event_serializer.sv
// Directed bench for pedge_event_serializer with a per-cycle reference model.
module tb_pedge_event_serializer;

  localparam int W = 8;
`ifdef PEDGE_TIMESTAMP_EN
  localparam int TSW = 4;
`else
  localparam int TSW = 16;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pedge = '0;
  logic [W-1:0] ovf_clr = '0;
  logic [W-1:0] pending, overflow;

  int npass = 0;
  int ntotal = 0;

  pedge_event_serializer_if #(.WIDTH(W), .TS_W(TSW)) ev_if ();

  pedge_event_serializer #(.WIDTH(W), .TS_W(TSW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pedge    (pedge),
    .ev       (ev_if),
    .pending  (pending),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (state after each posedge) -------------
  bit           m_valid = 1'b0;
  int           m_chan = 0;
  int           m_ptr = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_ovf = '0;
`ifdef PEDGE_TIMESTAMP_EN
  logic [TSW-1:0] m_cnt = '0;
  logic [TSW-1:0] m_ts = '0;
  logic [TSW-1:0] m_tsq [W];
`endif

  always @(posedge clk) begin
    logic [W-1:0] np, no;
    bit ld;
    int g, c;
    if (rst) begin
      m_valid = 1'b0; m_chan = 0; m_ptr = 0; m_pend = '0; m_ovf = '0;
`ifdef PEDGE_TIMESTAMP_EN
      m_cnt = '0; m_ts = '0;
      for (int i = 0; i < W; i++) m_tsq[i] = '0;
`endif
    end else begin
      ld = !m_valid || ev_if.ev_ready;
      g = -1;
      if (ld)
        for (int k = 0; k < W; k++) begin
          c = (m_ptr + k) % W;
          if (g < 0 && (m_pend[c] || pedge[c])) g = c;
        end
      for (int i = 0; i < W; i++) begin
        if (pedge[i] && m_pend[i] && g != i) no[i] = 1'b1;
        else if (ovf_clr[i])                 no[i] = 1'b0;
        else                                 no[i] = m_ovf[i];
        np[i] = (g == i) ? (pedge[i] && m_pend[i]) : (m_pend[i] || pedge[i]);
      end
`ifdef PEDGE_TIMESTAMP_EN
      if (g >= 0) m_ts = m_pend[g] ? m_tsq[g] : m_cnt;
      for (int i = 0; i < W; i++)
        if (pedge[i] && (!m_pend[i] || g == i)) m_tsq[i] = m_cnt;
      m_cnt = m_cnt + 1'b1;
`endif
      if (ld) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_chan = g;
          m_ptr  = (g + 1) % W;
        end
      end
      m_pend = np;
      m_ovf  = no;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Every cycle: registered outputs against the model.
  always @(negedge clk) begin
    chk("model_valid", 32'(ev_if.ev_valid), 32'(m_valid));
    chk("model_chan", 32'(ev_if.ev_chan), 32'(m_chan));
    chk("model_pending", 32'(pending), 32'(m_pend));
    chk("model_overflow", 32'(overflow), 32'(m_ovf));
`ifdef PEDGE_TIMESTAMP_EN
    chk("model_ts", 32'(ev_if.ev_ts), 32'(m_ts));
`endif
  end

  task automatic step(input bit r, input logic [W-1:0] pe, input bit rdy,
                      input logic [W-1:0] clr);
    rst = r; pedge = pe; ev_if.ev_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] rp, rc;
    ev_if.ev_ready = 1'b1;

    // Reset state
    repeat (3) step(1, 8'h00, 1, 8'h00);
    chk("rst_valid", 32'(ev_if.ev_valid), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Single pulse: one-cycle latency, then idle
    step(0, 8'h02, 1, 8'h00);
    chk("lat_valid", 32'(ev_if.ev_valid), 1);
    chk("lat_chan", 32'(ev_if.ev_chan), 1);
    step(0, 8'h00, 1, 8'h00);
    chk("lat_idle", 32'(ev_if.ev_valid), 0);
    chk("lat_ovf", 32'(overflow), 0);

    // Burst of three channels, back to back from ptr=0
    step(1, 8'h00, 1, 8'h00);
    step(0, 8'h0E, 1, 8'h00);
    chk("burst_c0", 32'(ev_if.ev_chan), 1);
    step(0, 8'h00, 1, 8'h00);
    chk("burst_c1", 32'(ev_if.ev_chan), 2);
    step(0, 8'h00, 1, 8'h00);
    chk("burst_c2", 32'(ev_if.ev_chan), 3);
    step(0, 8'h00, 1, 8'h00);
    chk("burst_idle", 32'(ev_if.ev_valid), 0);
    chk("burst_pend", 32'(pending), 0);

    // Backpressure, pending, overflow and clear
    step(0, 8'h02, 0, 8'h00);
    chk("bp_load", 32'(ev_if.ev_chan), 1);
    chk("bp_pend0", 32'(pending), 0);
    step(0, 8'h00, 0, 8'h00);
    step(0, 8'h00, 0, 8'h00);
    step(0, 8'h02, 0, 8'h00);
    chk("bp_hold", 32'(ev_if.ev_chan), 1);
    chk("bp_pend1", 32'(pending), 32'h02);
    chk("bp_noovf", 32'(overflow), 0);
    step(0, 8'h00, 0, 8'h00);
    step(0, 8'h00, 0, 8'h00);
    step(0, 8'h02, 0, 8'h00);
    chk("bp_ovf", 32'(overflow), 32'h02);
    step(0, 8'h00, 0, 8'h02);
    chk("bp_ovfclr", 32'(overflow), 0);
    step(0, 8'h02, 0, 8'h02);
    chk("bp_setwins", 32'(overflow), 32'h02);
    step(0, 8'h00, 1, 8'h02);
    chk("bp_release", 32'(ev_if.ev_chan), 1);
    chk("bp_release_pend", 32'(pending), 0);
    step(0, 8'h00, 1, 8'h00);
    chk("bp_drained", 32'(ev_if.ev_valid), 0);

    // Fairness between channels 0 and 7
    step(1, 8'h00, 1, 8'h00);
    step(0, 8'h81, 1, 8'h00);
    chk("fair0", 32'(ev_if.ev_chan), 0);
    step(0, 8'h81, 1, 8'h00);
    chk("fair1", 32'(ev_if.ev_chan), 7);
    step(0, 8'h81, 1, 8'h00);
    chk("fair2", 32'(ev_if.ev_chan), 0);
    step(0, 8'h81, 1, 8'h00);
    chk("fair3", 32'(ev_if.ev_chan), 7);
    repeat (3) step(0, 8'h00, 1, 8'hFF);
    chk("fair_drained", 32'(ev_if.ev_valid), 0);

    // Reset while an event is held and others pending
    step(0, 8'h01, 0, 8'h00);
    step(0, 8'h30, 0, 8'h00);
    chk("mrst_pre_valid", 32'(ev_if.ev_valid), 1);
    chk("mrst_pre_pend", 32'(pending), 32'h30);
    step(1, 8'h00, 0, 8'h00);
    chk("mrst_valid", 32'(ev_if.ev_valid), 0);
    chk("mrst_pend", 32'(pending), 0);
    step(0, 8'h81, 1, 8'h00);
    chk("mrst_ptr", 32'(ev_if.ev_chan), 0);
    repeat (3) step(0, 8'h00, 1, 8'h00);

`ifdef PEDGE_TIMESTAMP_EN
    // Timestamp captured at counter=15 survives the counter wrap
    step(1, 8'h00, 1, 8'h00);
    repeat (15) step(0, 8'h00, 1, 8'h00);
    step(0, 8'h04, 0, 8'h00);
    chk("ts_cap", 32'(ev_if.ev_ts), 15);
    repeat (3) step(0, 8'h00, 0, 8'h00);
    chk("ts_hold", 32'(ev_if.ev_ts), 15);
    chk("ts_hold_chan", 32'(ev_if.ev_chan), 2);
    step(0, 8'h00, 1, 8'h00);
`endif

    // Mixed traffic, model-checked every cycle
    for (int n = 0; n < 300; n++) begin
      rp = W'($urandom) & W'($urandom);
      rc = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      step(0, rp, $urandom_range(0, 3) != 0, rc);
    end
    repeat (12) step(0, 8'h00, 1, 8'h00);
    chk("final_idle", 32'(ev_if.ev_valid), 0);
    chk("final_pend", 32'(pending), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
